// File: rtl/aes_key_reverse_128_pkg.sv
// Shared constants, state encoding and rcon helper for the AES-128 inverse key schedule.
package aes_pkg;

    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Division by x in GF(2^8): undoes xtime, walking rcon backwards from 0x36.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        logic [7:0] res;
        if (r[0]) begin
            res = ((r ^ 8'h1b) >> 1) | 8'h80;
        end else begin
            res = r >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_key_reverse_128_if.sv
// Load/handshake bundle between the inverse key scheduler and its producer/consumer.
interface aes_key_reverse_128_if;

    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_round, done
    );

endinterface

// File: rtl/aes_key_reverse_128_step_inv.sv
// One backwards step of the AES-128 key schedule: round key i -> round key i-1.
module aes_key_step_inv (
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] key_prev
);

    logic [31:0] a, b, c, d;
    logic [31:0] a_prev, b_prev, c_prev, d_prev;
    logic [31:0] rot, sub;

    assign a = key[127:96];
    assign b = key[95:64];
    assign c = key[63:32];
    assign d = key[31:0];

    assign d_prev = d ^ c;
    assign c_prev = c ^ b;
    assign b_prev = b ^ a;

    // The forward g() was applied to the old last word, which is recovered first.
    assign rot = {d_prev[23:0], d_prev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (rot[8*i +: 8]),
            .out_byte (sub[8*i +: 8])
        );
    end

    assign a_prev   = a ^ sub ^ {rcon, 24'h0};
    assign key_prev = {a_prev, b_prev, c_prev, d_prev};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = TABLE[in_byte];

endmodule

// File: rtl/aes_key_reverse_128.sv
// Sequential AES-128 inverse key schedule: emits round keys 10 down to 0, one per handshake.
module aes_key_reverse_128
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_reverse_128_if.slave  bus
);

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] key_prev;

    aes_key_step_inv u_step (
        .key      (key_q),
        .rcon     (rcon_q),
        .key_prev (key_prev)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = EMIT;
                    key_d   = bus.key_in;
                    round_d = NUM_ROUNDS;
                    rcon_d  = RCON_LAST;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = FIN;
                    end else begin
                        key_d   = key_prev;
                        round_d = round_q - 4'd1;
                        rcon_d  = inv_xtime(rcon_q);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Status flags decode straight from the state register, so they stay glitch-free.
    assign bus.busy     = (state_q != IDLE);
    assign bus.rk_valid = (state_q == EMIT);
    assign bus.done     = (state_q == FIN);
    assign bus.rk_out   = key_q;
    assign bus.rk_round = round_q;

endmodule

// File: tb/tb_aes_key_reverse_128.sv
// Self-checking bench: forward-expansion reference model, randomized readiness and keys.
module tb_aes_key_reverse_128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    aes_key_reverse_128_if bus ();

    aes_key_reverse_128 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] exp_rk [11];
    logic [127:0] obs_rk [11];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] v;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            v = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_tab[x] = v;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // Forward FIPS-197 expansion; exp_rk[r] is round key r.
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left at a negedge; start is driven immediately on entry.
    task automatic run_key(input logic [127:0] k, input bit rand_ready, input bit poke_start,
                           output int lat);
        int   c = 0;
        int   exp_round = 10;
        int   accepted = 0;
        bit   stalled = 1'b0;
        bit   seen_done = 1'b0;
        bit   rdy;
        logic [127:0] p_out = '0;
        logic [3:0]   p_round = '0;
        expand(k);
        lat = -1;
        bus.start    = 1'b1;
        bus.key_in   = exp_rk[10];
        bus.rk_ready = 1'b0;
        while (!seen_done && c < 300) begin
            @(negedge clk);
            c++;
            bus.start  = 1'b0;
            bus.key_in = rand128();
            if (poke_start && c == 4) bus.start = 1'b1;
            if (bus.done) begin
                seen_done = 1'b1;
                lat = c;
                check_eq("keys_accepted", 128'(accepted), 128'd11);
                check_eq("busy_in_fin", 128'(bus.busy), 128'd1);
                bus.rk_ready = 1'b0;
            end else begin
                check_eq("rk_valid", 128'(bus.rk_valid), 128'd1);
                check_eq("busy", 128'(bus.busy), 128'd1);
                if (stalled) begin
                    check_eq("stall_key", bus.rk_out, p_out);
                    check_eq("stall_round", 128'(bus.rk_round), 128'(p_round));
                end
                if (exp_round < 0) begin
                    check_eq("overrun", 128'(bus.rk_valid), 128'd0);
                    exp_round = 0;
                end
                check_eq("rk_round", 128'(bus.rk_round), 128'(exp_round));
                check_eq("rk_out", bus.rk_out, exp_rk[exp_round]);
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.rk_ready = rdy;
                p_out   = bus.rk_out;
                p_round = bus.rk_round;
                stalled = !rdy;
                if (rdy) begin
                    obs_rk[exp_round] = bus.rk_out;
                    accepted++;
                    exp_round--;
                end
            end
        end
        if (!seen_done) check_eq("done_timeout", 128'd0, 128'd1);
        @(negedge clk);
        check_eq("idle_busy", 128'(bus.busy), 128'd0);
        check_eq("idle_done", 128'(bus.done), 128'd0);
        check_eq("idle_valid", 128'(bus.rk_valid), 128'd0);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        int lat;
        int n;
        logic [127:0] k;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
        build_sbox();

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 128'(bus.busy), 128'd0);
        check_eq("rst_valid", 128'(bus.rk_valid), 128'd0);
        check_eq("rst_done", 128'(bus.done), 128'd0);
        check_eq("rst_out", bus.rk_out, 128'd0);
        check_eq("rst_round", 128'(bus.rk_round), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer run with ready held high.
        run_key(FIPS_KEY, 1'b0, 1'b0, lat);
        check_eq("fips_latency", 128'(lat), 128'd12);
        check_eq("fips_r10", obs_rk[10], FIPS_R10);
        check_eq("fips_r9", obs_rk[9], FIPS_R9);
        check_eq("fips_r0", obs_rk[0], FIPS_KEY);

        // Back-to-back start, random backpressure, then a start poked mid-run.
        run_key(FIPS_KEY, 1'b1, 1'b0, lat);
        check_eq("b2b_r0", obs_rk[0], FIPS_KEY);
        run_key(FIPS_KEY, 1'b0, 1'b1, lat);
        check_eq("poke_latency", 128'(lat), 128'd12);
        check_eq("poke_r0", obs_rk[0], FIPS_KEY);

        // Reset while round 5 is on the bus.
        k = rand128();
        expand(k);
        bus.start    = 1'b1;
        bus.key_in   = exp_rk[10];
        bus.rk_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.rk_round != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_round5", 128'(bus.rk_round), 128'd5);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 128'(bus.busy), 128'd0);
        check_eq("abort_valid", 128'(bus.rk_valid), 128'd0);
        check_eq("abort_out", bus.rk_out, 128'd0);
        check_eq("abort_round", 128'(bus.rk_round), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_done", 128'(bus.done), 128'd0);
            check_eq("abort_stays_idle", 128'(bus.busy), 128'd0);
        end
        run_key(k, 1'b0, 1'b0, lat);
        check_eq("after_abort_r0", obs_rk[0], k);

        // Round-trip over random keys.
        for (int i = 0; i < 100; i++) begin
            k = rand128();
            run_key(k, 1'(i % 2), 1'b0, lat);
            check_eq("roundtrip_r0", obs_rk[0], k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
